// File: rtl/axi_lite_slave_regfile.sv
// AXI-Lite responder with a word-addressed register file exposed on REG_OUT.
// Optional feature macro: AXIL_WSTRB_EN (byte-strobe writes; REG_WIDTH must be 32).
module axi_lite_slave_regfile #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [ADDR_WIDTH-1:0]         AWADDR,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [REG_WIDTH-1:0]          WDATA,
    input  logic [REG_WIDTH/8-1:0]        WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [ADDR_WIDTH-1:0]         ARADDR,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [REG_WIDTH-1:0]          RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic [NUM_REGS*REG_WIDTH-1:0] REG_OUT
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = REG_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return addr < ADDR_WIDTH'(NUM_REGS * 4);
    endfunction

`ifdef AXIL_WSTRB_EN
    function automatic logic [REG_WIDTH-1:0] merge_strb(
        input logic [REG_WIDTH-1:0] old_v,
        input logic [REG_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]    strb
    );
        logic [REG_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return res;
    endfunction
`endif

    w_state_t               w_state_q;
    r_state_t               r_state_q;
    logic                   awready_q, wready_q, bvalid_q;
    logic [1:0]             bresp_q;
    logic                   aw_done_q, w_done_q;
    logic [ADDR_WIDTH-1:0]  awaddr_q;
    logic [REG_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]      wstrb_q;
    logic                   arready_q, rvalid_q;
    logic [1:0]             rresp_q;
    logic [REG_WIDTH-1:0]   rdata_q;
    logic [REG_WIDTH-1:0]   regs_q [NUM_REGS];

    logic                   aw_hs_s, w_hs_s, aw_have_s, w_have_s;
    logic [ADDR_WIDTH-1:0]  waddr_s;
    logic [REG_WIDTH-1:0]   wdata_s, wr_val_s;
    logic [STRB_W-1:0]      wstrb_s;
    logic [IDX_W-1:0]       widx_s, ridx_s;

    // A channel handshaking this cycle counts as already latched, so AW+W together resolve on one edge.
    always_comb begin
        aw_hs_s   = AWVALID && awready_q;
        w_hs_s    = WVALID && wready_q;
        aw_have_s = aw_done_q || aw_hs_s;
        w_have_s  = w_done_q || w_hs_s;
        waddr_s   = aw_done_q ? awaddr_q : AWADDR;
        wdata_s   = w_done_q ? wdata_q : WDATA;
        wstrb_s   = w_done_q ? wstrb_q : WSTRB;
        widx_s    = waddr_s[2 +: IDX_W];
        ridx_s    = ARADDR[2 +: IDX_W];
`ifdef AXIL_WSTRB_EN
        wr_val_s  = merge_strb(regs_q[widx_s], wdata_s, wstrb_s);
`else
        wr_val_s  = wdata_s;
`endif
    end

`ifndef AXIL_WSTRB_EN
    logic unused_s;
    assign unused_s = ^wstrb_s;
`endif

    // Write FSM: independent AW/W capture, register update and B response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_have_s && w_have_s) begin
                        if (addr_in_range(waddr_s)) begin
                            regs_q[widx_s] <= wr_val_s;
                            bresp_q        <= RESP_OKAY;
                        end else begin
                            bresp_q        <= RESP_SLVERR;
                        end
                        bvalid_q  <= 1'b1;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        w_state_q <= W_RESP;
                    end else begin
                        if (aw_hs_s) begin
                            awaddr_q  <= AWADDR;
                            aw_done_q <= 1'b1;
                        end
                        if (w_hs_s) begin
                            wdata_q  <= WDATA;
                            wstrb_q  <= WSTRB;
                            w_done_q <= 1'b1;
                        end
                        awready_q <= !aw_have_s;
                        wready_q  <= !w_have_s;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    bvalid_q  <= 1'b0;
                    bresp_q   <= RESP_OKAY;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: registers the addressed value (pre-write on a same-edge write) and holds it until RREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ARVALID && arready_q) begin
                        if (addr_in_range(ARADDR)) begin
                            rdata_q <= regs_q[ridx_s];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        rvalid_q  <= 1'b0;
                        rdata_q   <= '0;
                        rresp_q   <= RESP_OKAY;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rvalid_q  <= 1'b0;
                    rdata_q   <= '0;
                    rresp_q   <= RESP_OKAY;
                    arready_q <= 1'b0;
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign REG_OUT[g*REG_WIDTH +: REG_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Scoreboard bench for axi_lite_slave_regfile: B/R responses checked against queued expectations.
`timescale 1ns/1ps
module tb_axi_lite_slave_regfile;

    localparam int RW = 32;
    localparam int AW = 32;
    localparam int NR = 8;

    logic            ACLK = 1'b0;
    logic            ARESETN;
    logic [AW-1:0]   AWADDR;
    logic            AWVALID;
    logic            AWREADY;
    logic [RW-1:0]   WDATA;
    logic [RW/8-1:0] WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic            ARVALID;
    logic            ARREADY;
    logic [RW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;
    logic [NR*RW-1:0] REG_OUT;

    int total = 0;
    int bad   = 0;
    logic [1:0]  exp_b_q [$];
    logic [33:0] exp_r_q [$];
    logic [31:0] model [NR];

    always #5 ACLK = ~ACLK;

    axi_lite_slave_regfile #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .REG_OUT(REG_OUT)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every B/R handshake.
    always @(negedge ACLK) begin
        if (ARESETN === 1'b1) begin
            if (BVALID && BREADY) begin
                if (exp_b_q.size() > 0) check("bresp", 64'(BRESP), 64'(exp_b_q.pop_front()));
                else check("b_extra", 64'(BVALID), 64'd0);
            end
            if (RVALID && RREADY) begin
                if (exp_r_q.size() > 0) check("rresp_rdata", 64'({RRESP, RDATA}), 64'(exp_r_q.pop_front()));
                else check("r_extra", 64'(RVALID), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic in_rng(input logic [31:0] addr);
        return addr < 32'(NR * 4);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] m;
        if (in_rng(addr)) begin
`ifdef AXIL_WSTRB_EN
            for (int b = 0; b < 4; b++) m[b*8 +: 8] = strb[b] ? 8'hFF : 8'h00;
`else
            m = 32'hFFFF_FFFF;
            if (strb == 4'hF) m = 32'hFFFF_FFFF;
`endif
            model[addr[4:2]] = (model[addr[4:2]] & ~m) | (data & m);
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < NR; i++) check($sformatf("reg%0d", i), 64'(REG_OUT[i*RW +: RW]), 64'(model[i]));
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
        exp_b_q.push_back(in_rng(addr) ? 2'b00 : 2'b10);
        model_write(addr, data, strb);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        check("wr_bvalid", 64'(BVALID), 64'd1);
        check_regs();
        tick();
        check("wr_bdone", 64'(BVALID), 64'd0);
    endtask

    task automatic rd(input logic [31:0] addr);
        ARADDR = addr; ARVALID = 1'b1;
        exp_r_q.push_back(in_rng(addr) ? {2'b00, model[addr[4:2]]} : {2'b10, 32'h0});
        tick();
        ARVALID = 1'b0;
        check("rd_rvalid", 64'(RVALID), 64'd1);
        check("rd_arready_low", 64'(ARREADY), 64'd0);
        tick();
        check("rd_rdone", 64'(RVALID), 64'd0);
        check("rd_arready_back", 64'(ARREADY), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, 64'(AWREADY), 64'd0);
        check({tag, "_wready"}, 64'(WREADY), 64'd0);
        check({tag, "_arready"}, 64'(ARREADY), 64'd0);
        check({tag, "_bvalid"}, 64'(BVALID), 64'd0);
        check({tag, "_rvalid"}, 64'(RVALID), 64'd0);
        check({tag, "_bresp_rresp"}, 64'({BRESP, RRESP}), 64'd0);
        check({tag, "_rdata"}, 64'(RDATA), 64'd0);
        check_regs();
    endtask

    initial begin
        ARESETN = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        tick();
        tick();
        check_all_zero("reset");
        ARESETN = 1'b1;
        #1;
        check("pre_edge_awready", 64'(AWREADY), 64'd0);
        tick();
        check("post_rst_awready", 64'(AWREADY), 64'd1);
        check("post_rst_wready", 64'(WREADY), 64'd1);
        check("post_rst_arready", 64'(ARREADY), 64'd1);

        // Same-cycle AW/W, then read back
        wr(32'h4, 32'hDEAD_BEEF, 4'hF);
        rd(32'h4);

        // W leads AW by three cycles
        WDATA = 32'h1234_5678; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("wlead_wready", 64'(WREADY), 64'd0);
            check("wlead_awready", 64'(AWREADY), 64'd1);
            check("wlead_bvalid", 64'(BVALID), 64'd0);
            tick();
        end
        AWADDR = 32'h8; AWVALID = 1'b1;
        exp_b_q.push_back(2'b00);
        model_write(32'h8, 32'h1234_5678, 4'hF);
        tick();
        AWVALID = 1'b0;
        check("wlead_bvalid_after_aw", 64'(BVALID), 64'd1);
        check_regs();
        tick();
        check("wlead_ready_back", 64'({AWREADY, WREADY}), 64'd3);

        // Out of range
        wr(32'h20, 32'h5555_5555, 4'hF);
        rd(32'h20);

        // RREADY held low for five cycles
        wr(32'h4, 32'hA5A5_A5A5, 4'hF);
        RREADY = 1'b0;
        ARADDR = 32'h4; ARVALID = 1'b1;
        exp_r_q.push_back({2'b00, 32'hA5A5_A5A5});
        tick();
        ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_rvalid", 64'(RVALID), 64'd1);
            check("hold_rdata", 64'(RDATA), 64'hA5A5_A5A5);
            check("hold_arready", 64'(ARREADY), 64'd0);
            tick();
        end
        RREADY = 1'b1;
        check("hold_rvalid_last", 64'(RVALID), 64'd1);
        tick();
        check("hold_done_arready", 64'(ARREADY), 64'd1);
        check("hold_done_rvalid", 64'(RVALID), 64'd0);
        check("hold_done_rdata", 64'(RDATA), 64'd0);

        // Byte strobes
        wr(32'h0, 32'hFFFF_FFFF, 4'hF);
        wr(32'h0, 32'h0000_0000, 4'b0101);
`ifdef AXIL_WSTRB_EN
        check("strb_reg0", 64'(REG_OUT[31:0]), 64'hFF00_FF00);
`else
        check("strb_reg0", 64'(REG_OUT[31:0]), 64'h0);
`endif

        // Same-edge read and write to one register returns the old value
        wr(32'hC, 32'h1111_1111, 4'hF);
        exp_r_q.push_back({2'b00, 32'h1111_1111});
        exp_b_q.push_back(2'b00);
        model_write(32'hC, 32'h2222_2222, 4'hF);
        AWADDR = 32'hC; WDATA = 32'h2222_2222; WSTRB = 4'hF; ARADDR = 32'hC;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("rw_bvalid", 64'(BVALID), 64'd1);
        check("rw_rvalid", 64'(RVALID), 64'd1);
        check_regs();
        tick();

        // Top register and ignored low address bits
        wr(32'h1C, 32'h0BAD_F00D, 4'hF);
        rd(32'h1F);

        // Reset while both responses are pending
        BREADY = 1'b0; RREADY = 1'b0;
        AWADDR = 32'h18; WDATA = 32'h77; WSTRB = 4'hF; ARADDR = 32'h4;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        model_write(32'h18, 32'h77, 4'hF);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("abort_bvalid", 64'(BVALID), 64'd1);
        check("abort_rvalid", 64'(RVALID), 64'd1);
        ARESETN = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        #1;
        check_all_zero("abort");
        tick();
        tick();
        ARESETN = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
        tick();
        check("rerst_readys", 64'({AWREADY, WREADY, ARREADY}), 64'd7);
        wr(32'h10, 32'hCAFE_F00D, 4'hF);
        rd(32'h10);

        tick();
        check("sb_b_left", 64'(exp_b_q.size()), 64'd0);
        check("sb_r_left", 64'(exp_r_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regfile.md
Name: axi_lite_slave_regfile

Overview:
AXI-Lite responder (slave) with an internal memory-mapped register file. It sits opposite the team's AXI-Lite master interface and serves all five channels: AW, W, B, AR and R. It decodes word addresses, answers out-of-range accesses with SLVERR, and exposes the register contents for downstream logic.

Parameters:
REG_WIDTH, 32, data width and register width in bits; must be 32 when AXIL_WSTRB_EN is defined.
ADDR_WIDTH, 32, AXADDR width in bits.
NUM_REGS, 8, number of registers; a power of two, at least 2.

Ports:
ACLK  input  1  clock
ARESETN  input  1  reset
AWADDR  input  ADDR_WIDTH  write address
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
WDATA  input  REG_WIDTH  write data
WSTRB  input  REG_WIDTH/8  byte strobes; only used with AXIL_WSTRB_EN
WVALID  input  1  write data valid
WREADY  output  1  write data ready
BRESP  output  2  write response: 00 OKAY, 10 SLVERR
BVALID  output  1  write response valid
BREADY  input  1  write response ready
ARADDR  input  ADDR_WIDTH  read address
ARVALID  input  1  read address valid
ARREADY  output  1  read address ready
RDATA  output  REG_WIDTH  read data
RRESP  output  2  read response
RVALID  output  1  read data valid
RREADY  input  1  read data ready
REG_OUT  output  NUM_REGS*REG_WIDTH  flattened register contents; reg i at bits [i*REG_WIDTH +: REG_WIDTH]

Behaviour:
- Reset: ARESETN is asynchronous, active-low; clock is ACLK.
- During reset, every output is 0 and all registers are 0.
- Once out of reset, AWREADY, WREADY and ARREADY return to 1 on the first ACLK edge.
- Address decode: index = addr[2 +: log2(NUM_REGS)]. The access is in range iff addr < NUM_REGS*4. addr[1:0] is ignored.
- Write FSM has two states, W_IDLE and W_RESP.
  - W_IDLE: AWREADY and WREADY are each high until their own handshake completes. Address and data are latched independently, in either order or in the same cycle. A channel that has already handshaked drops its READY and waits for the other.
  - When both are latched: on the next edge the register is written (in-range only), BRESP is set (OKAY in range, SLVERR otherwise), BVALID goes to 1 and the FSM enters W_RESP.
  - Latency: AW and W together in cycle N gives BVALID=1 in cycle N+1 and REG_OUT updated in cycle N+1.
  - W_RESP: BVALID and BRESP are held stable until BREADY. After the BVALID&&BREADY edge, BVALID=0 and AWREADY=WREADY=1 on that same edge, then back to W_IDLE.
  - An out-of-range write changes no register.
- Read FSM has two states, R_IDLE and R_DATA.
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY, the next edge registers RDATA (register value, or 0 if out of range), sets RRESP, sets RVALID=1, ARREADY=0, and moves to R_DATA.
  - Latency: one cycle from the AR handshake to RVALID.
  - R_DATA: RDATA, RRESP and RVALID are held stable until RREADY. This also works for masters that raise RREADY only after seeing RVALID. On the RVALID&&RREADY edge: RVALID=0, RDATA=0, RRESP=0, ARREADY=1.
- The read and write FSMs run independently and concurrently.
- Read and write to the same register resolving on the same edge: the read returns the pre-write value.
- VALID deasserted before READY is a master protocol violation; behaviour is unspecified.
- ARESETN asserted mid-transaction: both FSMs abort to idle, all outputs go to 0 and registers clear. No response is issued for the aborted transaction.

Optional Feature:
- Macro: AXIL_WSTRB_EN.
- Defined: a write updates only the bytes whose WSTRB bit is 1. WSTRB=0 gives BRESP OKAY with no change.
- Undefined: WSTRB is ignored and all bytes are written.

Test Plan:
- Reset, then AW=0x4 and W=0xDEADBEEF in the same cycle with BREADY=1 -> BVALID=1 one cycle later, BRESP=00, REG_OUT reg1=0xDEADBEEF; then AR=0x4 with RREADY=1 -> RVALID one cycle after the handshake, RDATA=0xDEADBEEF, RRESP=00.
- W handshake 3 cycles before AW (addr 0x8, data 0x12345678) -> WREADY low while waiting, BVALID one cycle after the AW handshake, reg2=0x12345678.
- Write and read at addr 0x20 with NUM_REGS=8 -> BRESP=10, no register changes, RDATA=0, RRESP=10.
- Hold RREADY=0 for 5 cycles after RVALID (reg1=0xA5A5A5A5) -> RVALID/RDATA stable throughout, ARREADY=0 until the handshake, ARREADY=1 the cycle after.
- With AXIL_WSTRB_EN: reg0=0xFFFFFFFF, write 0x00000000 with WSTRB=0101 -> reg0=0xFF00FF00. Without the macro -> reg0=0x00000000.
- Assert ARESETN low while BVALID=1 and RVALID=1 -> all outputs and REG_OUT go to 0 immediately; after release, READYs=1 and a new write completes normally.
